// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// APB3 bus bundle between the CPU-side bridge (master) and the peripheral
// slaves.
//   PADDR    [31:0]            address of the current transfer
//   PWRITE                     1 = write, 0 = read
//   PENABLE                    high in the ACCESS phase
//   PWDATA   [31:0]            write data
//   PSEL     [SLV_NUM-1:0]     one-hot slave select
//   PRDATA_s [SLV_NUM-1:0][31:0] per-slave read data
//   PREADY_s [SLV_NUM-1:0]     per-slave ready
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
   parameter int SLV_NUM = 4
);
   logic [31:0]               PADDR;
   logic                      PWRITE;
   logic                      PENABLE;
   logic [31:0]               PWDATA;
   logic [SLV_NUM-1:0]        PSEL;
   logic [SLV_NUM-1:0][31:0]  PRDATA_s;
   logic [SLV_NUM-1:0]        PREADY_s;

   modport master (
      output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
      input  PRDATA_s, PREADY_s
   );

   modport slave (
      input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
      output PRDATA_s, PREADY_s
   );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Converts single CPU data-memory requests into APB3 transfers. The target
// slave is decoded from addr[15:12] inside the BASE_ADDR[31:16] region; the
// bridge walks IDLE -> SETUP -> ACCESS -> RESP, waits for the selected
// slave's PREADY (bounded by TIMEOUT ACCESS cycles) and reports completion
// with a one-cycle done pulse plus err.
// Ports:
//   PCLK, PRESET        clock, synchronous active-high reset
//   req, addr, we,      CPU request (sampled only in IDLE), byte address,
//   wdata               direction and write data
//   rdata               last successfully read word (valid with done)
//   done, err           one-cycle completion pulse and its error flag
//   busy                high whenever the bridge is not IDLE
//   apb                 APB master side (PADDR/PWRITE/PENABLE/PWDATA/PSEL out,
//                       PRDATA_s/PREADY_s in); its SLV_NUM must match ours
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int          SLV_NUM   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          TIMEOUT   = 16
) (
   input  logic                PCLK,
   input  logic                PRESET,
   input  logic                req,
   input  logic [31:0]         addr,
   input  logic                we,
   input  logic [31:0]         wdata,
   output logic [31:0]         rdata,
   output logic                done,
   output logic                err,
   output logic                busy,
   apb_master_bridge_if.master apb
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [SLV_NUM-1:0] sel_r, sel_s, sel_dec_s;
   logic [7:0]         wait_cnt_r, wait_cnt_s;
   logic [31:0]        paddr_r, paddr_s, pwdata_r, pwdata_s, rdata_r, rdata_s;
   logic               pwrite_r, pwrite_s, penable_r, penable_s;
   logic [SLV_NUM-1:0] psel_r, psel_s;
   logic               done_r, done_s, err_r, err_s, busy_r, busy_s;
   logic               hit_s, pready_sel_s;
   logic [31:0]        prdata_sel_s;

   // Decode the CPU address into a one-hot slave select; an index beyond
   // SLV_NUM leaves the select empty, which counts as a miss.
   always_comb begin
      sel_dec_s = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         sel_dec_s[i] = (addr[15:12] == 4'(i));
      end
      hit_s = (addr[31:16] == BASE_ADDR[31:16]) && (|sel_dec_s);
   end

   // Only the latched slave's PREADY/PRDATA are observed; all others masked.
   always_comb begin
      pready_sel_s = |(apb.PREADY_s & sel_r);
      prdata_sel_s = 32'h0000_0000;
      for (int i = 0; i < SLV_NUM; i++) begin
         prdata_sel_s = prdata_sel_s | (apb.PRDATA_s[i] & {32{sel_r[i]}});
      end
   end

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so that every bus/CPU output comes straight from a flop.
   always_comb begin
      state_s    = state_r;
      sel_s      = sel_r;
      wait_cnt_s = wait_cnt_r;
      paddr_s    = paddr_r;
      pwrite_s   = pwrite_r;
      pwdata_s   = pwdata_r;
      rdata_s    = rdata_r;
      psel_s     = '0;
      penable_s  = 1'b0;
      done_s     = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (req) begin
               paddr_s  = addr;
               pwrite_s = we;
               pwdata_s = wdata;
               sel_s    = sel_dec_s;
               if (hit_s) begin
                  state_s    = SETUP;
                  psel_s     = sel_dec_s;
                  wait_cnt_s = 8'd0;
               end else begin
                  state_s = RESP;
                  done_s  = 1'b1;
                  err_s   = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            state_s   = ACCESS;
            psel_s    = sel_r;
            penable_s = 1'b1;
         end
         ACCESS: begin
            if (pready_sel_s) begin
               // PREADY wins even in the cycle the wait budget runs out.
               state_s = RESP;
               done_s  = 1'b1;
               rdata_s = pwrite_r ? rdata_r : prdata_sel_s;
            end else if ((wait_cnt_r + 8'd1) == TIMEOUT_C) begin
               state_s    = RESP;
               wait_cnt_s = wait_cnt_r + 8'd1;
               done_s     = 1'b1;
               err_s      = 1'b1;
            end else begin
               wait_cnt_s = wait_cnt_r + 8'd1;
               psel_s     = sel_r;
               penable_s  = 1'b1;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r    <= IDLE;
         sel_r      <= '0;
         wait_cnt_r <= 8'd0;
         paddr_r    <= 32'h0000_0000;
         pwrite_r   <= 1'b0;
         pwdata_r   <= 32'h0000_0000;
         rdata_r    <= 32'h0000_0000;
         psel_r     <= '0;
         penable_r  <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         sel_r      <= sel_s;
         wait_cnt_r <= wait_cnt_s;
         paddr_r    <= paddr_s;
         pwrite_r   <= pwrite_s;
         pwdata_r   <= pwdata_s;
         rdata_r    <= rdata_s;
         psel_r     <= psel_s;
         penable_r  <= penable_s;
         done_r     <= done_s;
         err_r      <= err_s;
         busy_r     <= busy_s;
      end
   end

   assign apb.PADDR   = paddr_r;
   assign apb.PWRITE  = pwrite_r;
   assign apb.PWDATA  = pwdata_r;
   assign apb.PSEL    = psel_r;
   assign apb.PENABLE = penable_r;
   assign rdata       = rdata_r;
   assign done        = done_r;
   assign err         = err_r;
   assign busy        = busy_r;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that converts single-transfer requests from the multi-cycle CPU's data-memory stage into APB3 transfers to memory-mapped peripherals (GPIO, timers, UART). It decodes the target slave from the address, sequences IDLE/SETUP/ACCESS phases, waits on PREADY, and returns read data or an error to the CPU. It sits between the CPU bus stage and all APB peripheral slaves.

## Interface
- SLV_NUM, 4: number of APB slaves; PSEL width.
- BASE_ADDR, 32'h1000_0000: base of the peripheral region; bits [31:16] are compared.
- TIMEOUT, 16: maximum ACCESS cycles without PREADY before abort (range 2..255).
- PCLK  in  1  clock.
- PRESET  in  1  reset; synchronous, active-high.
- req  in  1  CPU transfer request; sampled only in IDLE.
- addr  in  32  CPU byte address.
- we  in  1  1 = write, 0 = read.
- wdata  in  32  CPU write data.
- rdata  out  32  read data; valid with done on a successful read.
- done  out  1  one-cycle completion pulse.
- err  out  1  error flag, valid only with done.
- busy  out  1  high whenever state is not IDLE.
- PADDR  out  32  APB address (full latched CPU address).
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  SLV_NUM  one-hot slave select.
- PRDATA_s  in  SLV_NUM x 32  per-slave read data.
- PREADY_s  in  SLV_NUM  per-slave ready.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: when req=1, latch addr/we/wdata; decode slave index = addr[15:12]. Hit requires addr[31:16]==BASE_ADDR[31:16] and index < SLV_NUM. Hit -> SETUP; miss -> RESP with err=1 (no PSEL ever asserted).
- SETUP: PSEL[index]=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from latches. Always -> ACCESS after one cycle.
- ACCESS: PSEL[index]=1, PENABLE=1. Only PREADY_s[index] and PRDATA_s[index] are observed; other slaves ignored. PREADY=1: capture PRDATA_s[index] into rdata if read, -> RESP with err=0. Wait counter increments each ACCESS cycle without PREADY; on reaching TIMEOUT -> RESP with err=1, rdata unchanged.
- RESP: done=1 for exactly one cycle, err as determined; PSEL=0, PENABLE=0; -> IDLE.
- req in any non-IDLE state is ignored (CPU must hold req or re-issue after done). Latched fields do not change during a transfer.
- Writes never modify rdata; rdata holds last successful read value.
- Wait counter is 8 bits, cleared on entry to SETUP.
- PADDR, PWRITE, PWDATA hold their last values in IDLE/RESP (no glitching to zero).

## Timing
- Reset (PRESET=1 at a PCLK edge): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, done=0, err=0, busy=0, counter=0. Reset mid-ACCESS aborts the transfer immediately; no done pulse.
- Zero-wait slave (PREADY high in first ACCESS cycle): req at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done cycle 3.
- Codebase slaves register PREADY (high the cycle after sampling PSEL&PENABLE): req cycle 0, SETUP 1, ACCESS 2-3, done cycle 4, rdata valid cycle 4.
- Stale PREADY from a registered slave during RESP/IDLE/SETUP is ignored; PENABLE is low then, so the slave clears it before the next ACCESS.
- Back-to-back: next req accepted in the cycle after done (IDLE); minimum period 4 cycles for zero-wait slaves.
- Decode miss: req cycle 0, done+err cycle 1.
- Timeout: abort when TIMEOUT ACCESS cycles elapse with PREADY low; done+err in the following cycle. PREADY arriving in the same cycle as the counter reaching TIMEOUT wins (success).

## Test plan
- Reset: hold PRESET 2 cycles with req=1 -> all outputs zero, no PSEL, busy=0.
- Write: addr=0x1000_0004, wdata=0xA5, registered-PREADY slave 0 -> PSEL=4'b0001 cycles 1-3, PENABLE cycles 2-3, slave reg1=0xA5, done cycle 4, err=0.
- Read: addr=0x1000_2008, slave 2 returns 0x0000_005A -> PSEL=4'b0100, rdata=0x5A with done, err=0; slaves 0/1/3 PRDATA=0xFFFF_FFFF ignored.
- Decode miss: addr=0x1000_5000 and addr=0x2000_0000 -> PSEL never asserted, done+err at cycle 1, rdata unchanged.
- Timeout: slave 1 PREADY stuck low, TIMEOUT=16 -> 16 ACCESS cycles, done+err, then IDLE; req asserted during wait ignored.
- Reset mid-ACCESS: assert PRESET in cycle 2 of a read -> PSEL/PENABLE low next cycle, no done pulse, subsequent read completes normally.
